// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture: oversamples the raw LCD pins, tracks the raster and emits
// cleaned pixel / frame strobes for the triple-buffered video buffer.
module gb_lcd_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned H_PIXELS    = 160,
    parameter int unsigned V_LINES     = 144,
    parameter int unsigned TIMEOUT     = 65535,
    parameter int unsigned VS_WIDTH    = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       lcd_cp,
    input  logic       lcd_hsync,
    input  logic       lcd_vsync,
    input  logic [1:0] lcd_d,
    output logic       gb_pclk,
    output logic       gb_de,
    output logic       gb_vsync,
    output logic [1:0] gb_pixel,
    output logic       lcd_active,
    output logic       frame_ok,
    output logic       err_line
);

    localparam logic [7:0]  H_MAX   = 8'(H_PIXELS);
    localparam logic [7:0]  V_MAX   = 8'(V_LINES);
    localparam logic [8:0]  V_END   = 9'(V_LINES);
    localparam logic [15:0] TO_MAX  = 16'(TIMEOUT);
    localparam logic [7:0]  VS_LOAD = 8'(VS_WIDTH);

    typedef enum logic [1:0] {StWaitFrame, StLine, StHblank} state_e;

    // Stage SYNC_STAGES holds the previous synced sample; lcd_d rides alongside so the
    // data seen at a cp fall is the value present while cp was still high.
    logic [SYNC_STAGES:0][2:0] sig_sync_q;
    logic [SYNC_STAGES:0][1:0] d_sync_q;
    logic [2:0]                cur, prev;
    logic [1:0]                d_aligned;
    logic                      cp_fall, cp_edge, hs_rise, hs_fall, vs_rise;

    state_e      state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  vs_cnt_q, vs_cnt_d;
    logic        acc_q, acc_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_pix_q, pend_pix_d;
    logic        to_hit, cap, line_end, line_bad, vs_block;
    logic        pclk_d, de_d, active_d, frame_ok_d, err_d;
    logic [1:0]  pixel_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sig_sync_q <= '0;
            d_sync_q   <= '0;
        end else begin
            sig_sync_q <= {sig_sync_q[SYNC_STAGES-1:0], {lcd_vsync, lcd_hsync, lcd_cp}};
            d_sync_q   <= {d_sync_q[SYNC_STAGES-1:0], lcd_d};
        end
    end

    assign cur       = sig_sync_q[SYNC_STAGES-1];
    assign prev      = sig_sync_q[SYNC_STAGES];
    assign d_aligned = d_sync_q[SYNC_STAGES];
    assign cp_fall   = prev[0] & ~cur[0];
    assign cp_edge   = prev[0] ^ cur[0];
    assign hs_rise   = ~prev[1] & cur[1];
    assign hs_fall   = prev[1] & ~cur[1];
    assign vs_rise   = ~prev[2] & cur[2];

    // Raster tracking, line / frame checks and timeout.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_d      = acc_q;
        active_d   = lcd_active;
        frame_ok_d = frame_ok;
        err_d      = 1'b0;
        cap        = 1'b0;
        vs_cnt_d   = (vs_cnt_q != 8'd0) ? vs_cnt_q - 8'd1 : 8'd0;

        if (cp_edge) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
        to_hit = (to_cnt_q != TO_MAX) && (to_cnt_d == TO_MAX);

        line_end = (state_q != StWaitFrame) && (y_q < V_MAX) &&
                   (vs_rise || (hs_rise && state_q == StHblank));
        line_bad = line_end && (x_q != H_MAX);
        if (line_bad) begin
            err_d = 1'b1;
            acc_d = 1'b0;
        end

        if (vs_rise) begin
            frame_ok_d = acc_q && !line_bad && (({1'b0, y_q} + 9'd1) == V_END);
            acc_d      = 1'b1;
            state_d    = StLine;
            x_d        = '0;
            y_d        = '0;
            vs_cnt_d   = VS_LOAD;
            active_d   = 1'b1;
        end else if (hs_rise && state_q == StHblank) begin
            state_d = StLine;
            x_d     = '0;
            y_d     = (y_q != 8'hff) ? y_q + 8'd1 : y_q;
        end else if (hs_fall && state_q == StLine) begin
            state_d = StHblank;
        end

        // Line/frame resets above take effect before the pixel is placed.
        if (cp_fall) begin
            cap = (state_d != StWaitFrame) && (x_d < H_MAX) && (y_d < V_MAX);
            if (x_d != 8'hff) begin
                x_d = x_d + 8'd1;
            end
        end

        if (to_hit) begin
            state_d  = StWaitFrame;
            active_d = 1'b0;
            x_d      = '0;
            y_d      = '0;
            cap      = 1'b0;
        end
    end

    // Pixel strobe sequence: de, then de+pclk, then idle; held off while gb_vsync is high.
    always_comb begin
        vs_block   = (vs_cnt_d != 8'd0);
        de_d       = 1'b0;
        pclk_d     = 1'b0;
        pixel_d    = gb_pixel;
        pend_d     = pend_q;
        pend_pix_d = pend_pix_q;

        if (gb_de && !gb_pclk) begin
            if (vs_block) begin
                pend_d     = 1'b1;
                pend_pix_d = gb_pixel;
            end else begin
                de_d   = 1'b1;
                pclk_d = 1'b1;
            end
        end

        if (cap) begin
            pend_d     = 1'b1;
            pend_pix_d = d_aligned;
        end

        if (pend_d && !vs_block && !gb_de) begin
            de_d    = 1'b1;
            pixel_d = pend_pix_d;
            pend_d  = 1'b0;
        end

        if (to_hit) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= StWaitFrame;
            x_q        <= '0;
            y_q        <= '0;
            to_cnt_q   <= '0;
            vs_cnt_q   <= '0;
            acc_q      <= 1'b1;
            pend_q     <= 1'b0;
            pend_pix_q <= '0;
            gb_pclk    <= 1'b0;
            gb_de      <= 1'b0;
            gb_vsync   <= 1'b0;
            gb_pixel   <= '0;
            lcd_active <= 1'b0;
            frame_ok   <= 1'b0;
            err_line   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            to_cnt_q   <= to_cnt_d;
            vs_cnt_q   <= vs_cnt_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            pend_pix_q <= pend_pix_d;
            gb_pclk    <= pclk_d;
            gb_de      <= de_d;
            gb_vsync   <= vs_block;
            gb_pixel   <= pixel_d;
            lcd_active <= active_d;
            frame_ok   <= frame_ok_d;
            err_line   <= err_d;
        end
    end

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Randomized bench for gb_lcd_capture: drives LCD pin waveforms and checks the strobes
// against a pin-event reference model of the raster rules.
module tb_gb_lcd_capture;

    localparam int S   = 2;
    localparam int H   = 20;
    localparam int V   = 12;
    localparam int TO  = 300;
    localparam int VSW = 4;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       lcd_cp, lcd_hsync, lcd_vsync;
    logic [1:0] lcd_d;
    logic       gb_pclk, gb_de, gb_vsync, lcd_active, frame_ok, err_line;
    logic [1:0] gb_pixel;

    gb_lcd_capture #(
        .SYNC_STAGES(S),
        .H_PIXELS   (H),
        .V_LINES    (V),
        .TIMEOUT    (TO),
        .VS_WIDTH   (VSW)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .lcd_cp    (lcd_cp),
        .lcd_hsync (lcd_hsync),
        .lcd_vsync (lcd_vsync),
        .lcd_d     (lcd_d),
        .gb_pclk   (gb_pclk),
        .gb_de     (gb_de),
        .gb_vsync  (gb_vsync),
        .gb_pixel  (gb_pixel),
        .lcd_active(lcd_active),
        .frame_ok  (frame_ok),
        .err_line  (err_line)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model, advanced on pin events as the bench drives them.
    typedef struct {
        logic [1:0] v;
        int         when;
    } exp_t;
    exp_t exp_q[$];
    bit   m_active = 1'b0;
    bit   m_bad = 1'b0;
    int   m_x = 0, m_y = 0;
    int   exp_err = 0, exp_vs = 0, exp_pclk = 0;
    bit   exp_fok = 1'b0;
    int   vs_cyc = -1000;

    task automatic m_line_end();
        if (m_y < V && m_x != H) begin
            exp_err++;
            m_bad = 1'b1;
        end
    endtask

    task automatic m_vsync();
        if (m_active) begin
            m_line_end();
            exp_fok = !m_bad && (m_y + 1 == V);
        end else begin
            exp_fok = 1'b0;
        end
        m_active = 1'b1;
        m_bad    = 1'b0;
        m_x      = 0;
        m_y      = 0;
        vs_cyc   = cyc;
        exp_vs++;
    endtask

    task automatic m_hsync();
        if (m_active) begin
            m_line_end();
            if (m_y < 255) m_y++;
            m_x = 0;
        end
    endtask

    task automatic m_pix(input logic [1:0] v);
        exp_t e;
        if (m_active) begin
            if (m_x < H && m_y < V) begin
                // Earliest strobe is S+2 after the fall, but never inside the gb_vsync window.
                e.v    = v;
                e.when = (cyc + S + 2 > vs_cyc + S + VSW + 2) ? cyc + S + 2
                                                              : vs_cyc + S + VSW + 2;
                exp_q.push_back(e);
                exp_pclk++;
            end
            if (m_x < 255) m_x++;
        end
    endtask

    // Output monitor.
    int   n_pclk = 0, n_err = 0, n_vs = 0, vs_run = 0;
    logic de_prev = 1'b0, pclk_prev = 1'b0;
    always @(negedge clk_in) begin
        if (rst) begin
            de_prev   <= 1'b0;
            pclk_prev <= 1'b0;
            vs_run    <= 0;
        end else begin
            de_prev   <= gb_de;
            pclk_prev <= gb_pclk;
            if (gb_pclk) begin
                exp_t e;
                n_pclk <= n_pclk + 1;
                check("de_around_pclk", {de_prev, gb_de}, 3);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", gb_pixel, e.v);
                    check("pclk_cycle", cyc, e.when);
                end
            end
            if (pclk_prev) check("de_fall", gb_de, 0);
            if (gb_vsync) begin
                vs_run <= vs_run + 1;
                check("de_in_vsync", gb_de, 0);
            end else if (vs_run > 0) begin
                check("vsync_width", vs_run, VSW);
                n_vs   <= n_vs + 1;
                vs_run <= 0;
            end
            if (err_line) n_err <= n_err + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_pixel();
        logic [1:0] v;
        v      = 2'($urandom_range(0, 3));
        lcd_cp = 1'b1;
        lcd_d  = v;
        tick(int'($urandom_range(3, 4)));
        lcd_cp = 1'b0;
        m_pix(v);
        tick(int'($urandom_range(3, 4)));
    endtask

    // Starts a line (frame if with_vs); fall_at >= 0 drops cp that many cycles after hsync.
    task automatic line_start(input bit with_vs, input int fall_at);
        logic [1:0] v;
        v = 2'($urandom_range(0, 3));
        if (fall_at >= 0) begin
            lcd_cp = 1'b1;
            lcd_d  = v;
            tick(3);
        end
        lcd_hsync = 1'b1;
        lcd_vsync = with_vs;
        if (with_vs) m_vsync();
        else m_hsync();
        for (int i = 0; i < 4; i++) begin
            if (fall_at == i) begin
                lcd_cp = 1'b0;
                m_pix(v);
            end
            if (i == 3) begin
                lcd_hsync = 1'b0;
                lcd_vsync = 1'b0;
            end
            tick(1);
        end
        if (with_vs) begin
            check("frame_ok", frame_ok, exp_fok);
            check("lcd_active", lcd_active, m_active);
        end
        if (fall_at >= 0) tick(3);
    endtask

    task automatic send_frame(input int nlines, input int odd_line, input int odd_len,
                              input int first_fall);
        for (int l = 0; l < nlines; l++) begin
            int n  = (l == odd_line) ? odd_len : H;
            int fa = (l == 0) ? first_fall : ((l == 2) ? 0 : -1);
            line_start(l == 0, fa);
            for (int p = (fa >= 0) ? 1 : 0; p < n; p++) send_pixel();
            tick(2);
        end
    endtask

    task automatic settle_and_check(input string tag);
        tick(12);
        check({tag, "_pclk_total"}, n_pclk, exp_pclk);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_err_count"}, n_err, exp_err);
        check({tag, "_vsync_count"}, n_vs, exp_vs);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pclk"}, gb_pclk, 0);
        check({tag, "_de"}, gb_de, 0);
        check({tag, "_vsync"}, gb_vsync, 0);
        check({tag, "_pixel"}, gb_pixel, 0);
        check({tag, "_active"}, lcd_active, 0);
        check({tag, "_frame_ok"}, frame_ok, 0);
        check({tag, "_err_line"}, err_line, 0);
    endtask

    initial begin
        rst       = 1'b1;
        lcd_cp    = 1'b0;
        lcd_hsync = 1'b0;
        lcd_vsync = 1'b0;
        lcd_d     = 2'd0;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

        // Clean, short-line (coincident vsync+cp), clean (cp just after vsync), overlong, clean.
        send_frame(V, -1, 0, -1);
        send_frame(V, 5, H - 1, 0);
        send_frame(V, -1, 0, 2);
        send_frame(V + 3, 3, H + 10, -1);
        send_frame(V, -1, 0, -1);
        line_start(1'b1, -1);
        settle_and_check("raster");

        // Stop cp long enough to time out; later pixels are ignored until vsync.
        for (int i = 0; i < 5; i++) send_pixel();
        tick(TO - 20);
        check("active_before_timeout", lcd_active, m_active);
        tick(40);
        m_active = 1'b0;
        m_x      = 0;
        m_y      = 0;
        check("active_after_timeout", lcd_active, m_active);
        for (int i = 0; i < 6; i++) send_pixel();
        line_start(1'b0, -1);
        for (int i = 0; i < 6; i++) send_pixel();
        settle_and_check("timeout");
        send_frame(V, -1, 0, -1);
        line_start(1'b1, -1);

        // Reset in the middle of a line.
        for (int i = 0; i < H / 2; i++) send_pixel();
        tick(8);
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        m_active = 1'b0;
        m_x      = 0;
        m_y      = 0;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < H / 2; i++) send_pixel();
        line_start(1'b0, -1);
        for (int i = 0; i < 5; i++) send_pixel();
        settle_and_check("reset");
        send_frame(V, -1, 0, -1);
        line_start(1'b1, -1);
        settle_and_check("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Front-end capture stage for the raw Game Boy LCD bus. Oversamples the asynchronous LCD signals (pixel clock, line latch, frame sync, 2-bit data) in the `clk_in` domain and tracks the 160×144 raster. Emits cleaned `gb_pclk` / `gb_de` / `gb_vsync` / `gb_pixel` strobes directly to the triple-buffered video buffer, which writes on gated `gb_pclk` and swaps buffers on `gb_vsync`.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per LCD input (≥2).
- `H_PIXELS`, 160: pixels per visible line.
- `V_LINES`, 144: visible lines per frame.
- `TIMEOUT`, 65535: `clk_in` cycles without an `lcd_cp` edge before the LCD is declared off (16-bit counter).
- `VS_WIDTH`, 4: `gb_vsync` pulse width in `clk_in` cycles.

Ports:
- `clk_in` in 1: capture clock; must be ≥6× the `lcd_cp` rate.
- `rst` in 1: reset, asynchronous, active-high.
- `lcd_cp` in 1: LCD pixel clock, async; data valid at its falling edge.
- `lcd_hsync` in 1: line latch, async; rising edge starts a line.
- `lcd_vsync` in 1: frame sync, async; rising edge starts a frame.
- `lcd_d` in 2: pixel data, async.
- `gb_pclk` out 1: one-cycle pixel write strobe.
- `gb_de` out 1: pixel valid window bracketing `gb_pclk`.
- `gb_vsync` out 1: frame-start pulse, `VS_WIDTH` cycles.
- `gb_pixel` out 2: captured pixel value.
- `lcd_active` out 1: LCD running, i.e. not timed out.
- `frame_ok` out 1: last complete frame had exactly `V_LINES` lines of `H_PIXELS` pixels.
- `err_line` out 1: one-cycle pulse when a line ends with a pixel count ≠ `H_PIXELS`.

## Operation
- **Synchronization.** All four inputs pass through `SYNC_STAGES` flops.
  - `lcd_d` gets one extra stage so it is aligned with the synced `lcd_cp` history.
  - Edges are detected from the last two synced samples. Cycle k denotes the cycle an edge is detected.
- **Counters.**
  - `x` (8 bit) counts pixels captured in the current line, saturating at 255.
  - `y` (8 bit) counts lines in the frame, saturating at 255.
  - `to_cnt` (16 bit) counts cycles since the last `lcd_cp` edge (either polarity).
- **FSM states:** WAIT_FRAME, LINE, HBLANK.
  - WAIT_FRAME → LINE on a `lcd_vsync` rising edge: `y`=0, `x`=0, fire `gb_vsync`.
  - LINE → HBLANK on a `lcd_hsync` falling edge.
  - HBLANK → LINE on a `lcd_hsync` rising edge: `y`+1, `x`=0.
  - LINE / HBLANK → LINE on a `lcd_vsync` rising edge: frame restart.
  - any → WAIT_FRAME when `to_cnt` reaches `TIMEOUT`; `lcd_active`=0 at the same time.
  - `lcd_active` returns to 1 on the next `lcd_vsync` rising edge.
- **Pixel capture.** A `lcd_cp` falling edge in LINE or HBLANK with `x < H_PIXELS` and `y < V_LINES`:
  - latches `gb_pixel`, runs the output pulse sequence, and increments `x`.
  - Edges that fail these conditions only increment `x`, saturating; there is no output.
- **Line check.** On each `lcd_hsync` rising edge or `lcd_vsync` rising edge that ends a line (`y < V_LINES` and the line had started):
  - if `x != H_PIXELS`, pulse `err_line` and clear the frame-good accumulator.
- **Frame check.** On a `lcd_vsync` rising edge, `frame_ok` ← (accumulator clean and `y+1 == V_LINES`). The accumulator is then re-armed.
- **Simultaneous events.**
  - `vsync` rising edge plus `hsync` rising edge: the `vsync` edge wins, and `y` becomes 0.
  - `hsync` rising edge plus `cp` falling edge: `x` resets first, and the pixel is stored as `x`=0 of the new line.
- **Reset mid-operation.** All outputs go to 0 and the state goes to WAIT_FRAME. No pixel is emitted before the next `lcd_vsync` rising edge.

## Timing
- **Reset values:** `gb_pclk`=0, `gb_de`=0, `gb_vsync`=0, `gb_pixel`=00, `lcd_active`=0, `frame_ok`=0, `err_line`=0. All outputs are registered.
- **Pixel path.** `cp` falling edge detected at cycle k:
  - k+1: `gb_pixel` valid and `gb_de`=1.
  - k+2: `gb_pclk`=1, for this cycle only.
  - k+3: `gb_de`=0.
  - `gb_pixel` holds until the next captured pixel.
- **Latency.** Raw pin to `gb_pclk` is `SYNC_STAGES`+2 (to +3) cycles.
- **Frame path.** `gb_vsync` rises at k+1 after a `vsync` rising edge and stays high for `VS_WIDTH` cycles. `gb_de` stays 0 while `gb_vsync`=1; a pixel arriving inside that window is held off until the window ends.
- **Error timing.** `err_line` is asserted at k+1 of the terminating edge. `frame_ok` updates at k+1 of the `vsync` edge.
- **Timeout.** `lcd_active` falls on the cycle `to_cnt` reaches `TIMEOUT`.

## Test plan
- **Nominal frame:** `rst`, then a 50 MHz `clk_in` with a 4 MHz `cp` driving 144 lines × 160 pixels, data = x mod 4 → exactly 23040 `gb_pclk` pulses, `gb_pixel` sequence 0,1,2,3…, one `gb_vsync` 4 cycles wide, `frame_ok`=1 at the second `vsync`, no `err_line`.
- **Short line:** line 10 carries 159 pixels → one `err_line` pulse at the line-11 `hsync` edge; `frame_ok`=0 after that frame and back to 1 after the next clean frame.
- **Overlong raster:** a line of 170 pixels and a frame of 150 lines → only 160 `gb_pclk` pulses for that line, none for lines ≥144, `err_line` pulsed for the 170-pixel line.
- **Coincident edges:** `vsync` and `hsync` rising in the same cycle → `y`=0 and a single `gb_vsync`. `hsync` rising with a `cp` fall → that pixel is the first `gb_pclk` of the new line.
- **Timeout/reset:** stop `cp` for 65535 cycles → `lcd_active`=0 and later pixels are ignored until a `vsync` edge. Assert `rst` at mid-line pixel 80 → all outputs 0 immediately, with no output until the next `vsync` edge.
